// File: rtl/clause_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : clause_fetch_unit
// Brief    : Scans the clause RAM and streams one evaluator beat per clause
//            (unassign / mask / assignment / pole) through a 2-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module clause_fetch_unit #(
    parameter int NUM_CLAUSES = 1023,
    parameter int CIDX_W      = 10,
    parameter int NUM_VARS    = 64,
    parameter int VIDX_W      = 6,
    parameter int LITS        = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          cram_rd_en,
    output logic [CIDX_W-1:0]             cram_rd_addr,
    input  logic [LITS*(VIDX_W+2)-1:0]    cram_rd_data,
    input  logic [NUM_VARS-1:0]           var_assigned,
    input  logic [NUM_VARS-1:0]           var_value,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CIDX_W-1:0]             out_clause_idx,
    output logic                          out_last,
    output logic [LITS-1:0]               out_unassign,
    output logic [LITS-1:0]               out_clause_mask,
    output logic [LITS-1:0]               out_assignment,
    output logic [LITS-1:0]               out_clause_pole
);

    localparam int                c_LIT_W    = VIDX_W + 2;
    localparam int                c_VSPACE   = 1 << VIDX_W;
    localparam int                c_ENT_W    = CIDX_W + 1 + 4 * LITS;
    localparam logic [CIDX_W-1:0] c_LAST_IDX = CIDX_W'(NUM_CLAUSES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CIDX_W-1:0]   r_issue_ptr;
    logic [CIDX_W-1:0]   r_ret_idx;
    logic                r_inflight;
    logic [1:0]          r_count;
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [c_ENT_W-1:0]  r_mem [2];
    logic                w_push;
    logic                w_pop;
    logic [2:0]          w_occupancy;
    logic                w_credit_ok;
    logic [c_VSPACE-1:0] w_asg_ext;
    logic [c_VSPACE-1:0] w_val_ext;
    logic [LITS-1:0]     w_unassign;
    logic [LITS-1:0]     w_mask;
    logic [LITS-1:0]     w_assign;
    logic [LITS-1:0]     w_pole;
    logic [c_ENT_W-1:0]  w_beat;
    logic [c_ENT_W-1:0]  w_head;

    // Indices beyond NUM_VARS land on zero padding, so they read as unassigned.
    generate
        if (NUM_VARS >= c_VSPACE) begin : g_vars_full
            assign w_asg_ext = var_assigned[c_VSPACE-1:0];
            assign w_val_ext = var_value[c_VSPACE-1:0];
        end else begin : g_vars_pad
            assign w_asg_ext = {{(c_VSPACE-NUM_VARS){1'b0}}, var_assigned};
            assign w_val_ext = {{(c_VSPACE-NUM_VARS){1'b0}}, var_value};
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < LITS; gi++) begin : g_lit
            logic [VIDX_W-1:0] w_vidx;
            assign w_vidx         = cram_rd_data[gi*c_LIT_W +: VIDX_W];
            assign w_mask[gi]     = cram_rd_data[gi*c_LIT_W + VIDX_W + 1];
            assign w_pole[gi]     = cram_rd_data[gi*c_LIT_W + VIDX_W] & w_mask[gi];
            assign w_unassign[gi] = ~w_asg_ext[w_vidx] & w_mask[gi];
            assign w_assign[gi]   = w_val_ext[w_vidx] & w_asg_ext[w_vidx] & w_mask[gi];
        end
    endgenerate

    assign w_beat = {r_ret_idx, (r_ret_idx == c_LAST_IDX), w_unassign, w_mask, w_assign, w_pole};

    assign out_valid = (r_count != 2'd0);
    assign w_head    = out_valid ? r_mem[r_rd_ptr] : '0;
    assign {out_clause_idx, out_last, out_unassign,
            out_clause_mask, out_assignment, out_clause_pole} = w_head;

    assign w_pop       = out_valid & out_ready;
    assign w_push      = r_inflight & ~abort;
    // Entries already buffered plus the read in flight must leave a free slot.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit_ok = (w_occupancy < 3'd2);

    assign busy         = (r_state != S_IDLE);
    assign cram_rd_addr = r_issue_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cram_rd_en  = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                cram_rd_en = w_credit_ok;
                if (w_credit_ok && (r_issue_ptr == c_LAST_IDX)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if ((r_count == 2'd0) && !r_inflight) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
            cram_rd_en  = 1'b0;
            done        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_ptr <= '0;
            r_ret_idx   <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= cram_rd_en;
            if (cram_rd_en) begin
                r_ret_idx   <= r_issue_ptr;
                r_issue_ptr <= r_issue_ptr + CIDX_W'(1);
            end
            if ((r_state == S_IDLE) && start && !abort) r_issue_ptr <= '0;
        end
    end

    // A push at full occupancy lands in the slot the simultaneous pop vacates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
        end else if (abort) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_beat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire
